reflet_int_ctrl: RTL and testbench

Memory-mapped interrupt controller placed between up to `nb_src` peripheral interrupt sources and the four `ext_int` lines of `reflet_cpu`. Captures source events into a pending register, applies per-source masking, edge/level selection and routing to one of the four CPU lines, and drives `ext_int` as registered levels until software clears the pending bit. Sits on the CPU data bus alongside ROM/RAM, decoding a small register window at `base_addr`.

---
 rtl/reflet_int_ctrl_pkg.sv | 31 +++
 rtl/reflet_int_ctrl_irq_router.sv | 23 ++
 rtl/reflet_int_ctrl.sv | 111 +++++++++++
 tb/tb_reflet_int_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reflet_int_ctrl_pkg.sv
// reflet_int_ctrl register map and reset values, shared by the RTL, firmware headers and benches.
// Revision: 1.0
`default_nettype none

package reflet_int_ctrl_pkg;

   localparam logic [2:0] IRQ_PENDING  = 3'd0;
   localparam logic [2:0] IRQ_MASK     = 3'd1;
   localparam logic [2:0] IRQ_ROUTE_LO = 3'd2;
   localparam logic [2:0] IRQ_ROUTE_HI = 3'd3;
   localparam logic [2:0] IRQ_EDGE     = 3'd4;
   localparam int         IRQ_NB_REGS  = 5;

   localparam logic [7:0] RST_PENDING  = 8'h00;
   localparam logic [7:0] RST_MASK     = 8'h00;
   localparam logic [7:0] RST_ROUTE    = 8'h00;
   localparam logic [7:0] RST_EDGE     = 8'hFF;

   // Marks the 2-bit route fields that belong to existing sources.
   function automatic logic [15:0] route_field_mask(input int nb);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < nb) m[2*i +: 2] = 2'b11;
      end
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/reflet_int_ctrl_irq_router.sv
// reflet_irq_router: combinational map of pending & masked sources onto the four CPU lines.
// Revision: 1.0
`default_nettype none

module reflet_irq_router #(
   parameter int nb_src = 8
) (
   input  logic [nb_src-1:0] pending_i,
   input  logic [nb_src-1:0] mask_i,
   input  logic [15:0]       route_i,
   output logic [3:0]        req_o
);

   always_comb begin
      req_o = 4'b0000;
      for (int i = 0; i < nb_src; i++) begin
         if (pending_i[i] && mask_i[i]) req_o[route_i[2*i +: 2]] = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/reflet_int_ctrl.sv
// reflet_int_ctrl: memory-mapped interrupt controller feeding the four reflet_cpu ext_int lines.
// Revision: 1.0
`default_nettype none

module reflet_int_ctrl
   import reflet_int_ctrl_pkg::*;
#(
   parameter int         wordsize  = 8,
   parameter int         nb_src    = 8,
   parameter logic [7:0] base_addr = 8'hF0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [nb_src-1:0]   src_in,
   input  logic [wordsize-1:0] addr,
   input  logic [wordsize-1:0] data_in,
   input  logic                write_en,
   output logic [wordsize-1:0] data_out,
   output logic [3:0]          ext_int
);

   localparam logic [wordsize-1:0] BASE       = wordsize'(base_addr);
   localparam logic [15:0]         ROUTE_MASK = route_field_mask(nb_src);

   logic [nb_src-1:0]   src_prev_q, src_prev_d;
   logic [nb_src-1:0]   pending_q, pending_d;
   logic [nb_src-1:0]   mask_q, mask_d;
   logic [nb_src-1:0]   edge_q, edge_d;
   logic [15:0]         route_q, route_d;
   logic [3:0]          ext_int_q, ext_int_d;
   logic [wordsize-1:0] data_out_q, data_out_d;

   logic [wordsize-1:0] off;
   logic                sel;
   logic                wr;
   logic [nb_src-1:0]   set_v;
   logic [nb_src-1:0]   clr_v;
   logic [7:0]          rd8;
   logic [3:0]          req;

   assign off = addr - BASE;
   assign sel = (addr >= BASE) && (off < wordsize'(IRQ_NB_REGS));
   assign wr  = write_en && sel && enable;

   reflet_irq_router #(.nb_src(nb_src)) u_router (
      .pending_i (pending_q),
      .mask_i    (mask_q),
      .route_i   (route_q),
      .req_o     (req)
   );

   always_comb begin
      src_prev_d = src_in;
      mask_d     = mask_q;
      edge_d     = edge_q;
      route_d    = route_q;
      clr_v      = '0;
      // Edge-mode sources capture rising edges, level-mode ones every high cycle.
      set_v      = ((src_in & ~src_prev_q) & edge_q) | (src_in & ~edge_q);
      if (wr) begin
         case (off[2:0])
            IRQ_PENDING:  clr_v         = data_in[nb_src-1:0];
            IRQ_MASK:     mask_d        = data_in[nb_src-1:0];
            IRQ_ROUTE_LO: route_d[7:0]  = data_in[7:0] & ROUTE_MASK[7:0];
            IRQ_ROUTE_HI: route_d[15:8] = data_in[7:0] & ROUTE_MASK[15:8];
            IRQ_EDGE:     edge_d        = data_in[nb_src-1:0];
            default:      ;
         endcase
      end
      pending_d = (pending_q & ~clr_v) | set_v;
      ext_int_d = enable ? req : 4'b0000;

      rd8 = 8'h00;
      case (off[2:0])
         IRQ_PENDING:  rd8 = 8'(pending_q);
         IRQ_MASK:     rd8 = 8'(mask_q);
         IRQ_ROUTE_LO: rd8 = route_q[7:0];
         IRQ_ROUTE_HI: rd8 = route_q[15:8];
         IRQ_EDGE:     rd8 = 8'(edge_q);
         default:      rd8 = 8'h00;
      endcase
      data_out_d = (sel && enable) ? wordsize'(rd8) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_prev_q <= '0;
         pending_q  <= RST_PENDING[nb_src-1:0];
         mask_q     <= RST_MASK[nb_src-1:0];
         edge_q     <= RST_EDGE[nb_src-1:0];
         route_q    <= {RST_ROUTE, RST_ROUTE} & ROUTE_MASK;
         ext_int_q  <= 4'b0000;
         data_out_q <= '0;
      end else begin
         src_prev_q <= src_prev_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         route_q    <= route_d;
         ext_int_q  <= ext_int_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;
   assign ext_int  = ext_int_q;

endmodule

`default_nettype wire

// File: tb/tb_reflet_int_ctrl.sv
// Scoreboard bench for reflet_int_ctrl: stimulus queues expected reads and line states by cycle.
// Revision: 1.0
`default_nettype none

module tb_reflet_int_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] src_in;
   logic [7:0] addr;
   logic [7:0] data_in;
   logic       write_en;
   logic [7:0] data_out;
   logic [3:0] ext_int;

   reflet_int_ctrl #(.wordsize(8), .nb_src(8), .base_addr(8'hF0)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .src_in   (src_in),
      .addr     (addr),
      .data_in  (data_in),
      .write_en (write_en),
      .data_out (data_out),
      .ext_int  (ext_int)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      bit         is_int;
      logic [7:0] val;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every cycle, compare all entries due now; anything overdue is a miss.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            logic [7:0] got;
            got = sb[i].is_int ? {4'b0000, ext_int} : data_out;
            total++;
            if (got !== sb[i].val) begin
               bad++;
               $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name, cyc, got, sb[i].val);
            end
            sb.delete(i);
         end else if (sb[i].due < cyc) begin
            total++;
            bad++;
            $display("FAIL %s overdue cyc=%0d got=none exp=%h", sb[i].name, cyc, sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input int due, input bit is_int, input logic [7:0] v, input string n);
      exp_t e;
      e.due = due; e.is_int = is_int; e.val = v; e.name = n;
      sb.push_back(e);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      addr = a; data_in = d; write_en = 1'b1;
      tick();
      write_en = 1'b0; addr = 8'h00; data_in = 8'h00;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string n);
      addr = a;
      push(cyc + 1, 1'b0, exp, n);
      tick();
      addr = 8'h00;
   endtask

   int k;
   int m;

   initial begin
      reset = 1'b1; enable = 1'b1; src_in = 8'h00;
      addr = 8'h00; data_in = 8'h00; write_en = 1'b0;
      idle(3);
      reset = 1'b0;
      push(cyc, 1'b1, 8'h00, "rst_ext_int");
      push(cyc, 1'b0, 8'h00, "rst_data_out");
      rd(8'hF0, 8'h00, "rst_pending");
      rd(8'hF1, 8'h00, "rst_mask");
      rd(8'hF2, 8'h00, "rst_route_lo");
      rd(8'hF3, 8'h00, "rst_route_hi");
      rd(8'hF4, 8'hFF, "rst_edge");

      // Edge pulse on src0 to line 0, then write-1-clear.
      wr(8'hF1, 8'h01);
      k = cyc;
      src_in = 8'h01;
      push(k + 1, 1'b1, 8'h00, "edge_latency");
      for (int j = 2; j <= 4; j++) push(k + j, 1'b1, 8'h01, "edge_held");
      tick();
      src_in = 8'h00;
      idle(4);
      m = cyc;
      push(m + 1, 1'b1, 8'h01, "clr_pre");
      push(m + 2, 1'b1, 8'h00, "clr_drop");
      wr(8'hF0, 8'h01);
      idle(1);
      rd(8'hF0, 8'h00, "clr_pending");

      // Level mode src1 to line 3, cleared while the source is still high.
      wr(8'hF2, 8'h0C);
      wr(8'hF1, 8'h02);
      wr(8'hF4, 8'hFD);
      k = cyc;
      src_in = 8'h02;
      for (int j = 2; j <= 10; j++) push(k + j, 1'b1, 8'h08, "level_line3");
      for (int j = 0; j < 10; j++) begin
         if (j == 4) begin
            addr = 8'hF0; data_in = 8'h02; write_en = 1'b1;
         end else if (j == 6) begin
            addr = 8'hF0; write_en = 1'b0;
            push(cyc + 1, 1'b0, 8'h02, "level_pending_kept");
         end else begin
            addr = 8'h00; write_en = 1'b0;
         end
         tick();
      end
      write_en = 1'b0; addr = 8'h00; src_in = 8'h00;
      idle(1);
      m = cyc;
      push(m + 1, 1'b1, 8'h08, "level_pre_clr");
      push(m + 2, 1'b1, 8'h00, "level_drop");
      wr(8'hF0, 8'h02);
      idle(2);
      wr(8'hF4, 8'hFF);

      // Enable low: capture continues, delivery and writes suspended.
      wr(8'hF1, 8'h01);
      enable = 1'b0;
      k = cyc;
      src_in = 8'h01;
      for (int j = 1; j <= 3; j++) push(k + j, 1'b1, 8'h00, "dis_no_int");
      tick();
      src_in = 8'h00;
      wr(8'hF1, 8'h00);
      idle(1);
      enable = 1'b1;
      push(k + 4, 1'b1, 8'h01, "reenable_int");
      rd(8'hF1, 8'h01, "dis_write_ignored");
      rd(8'hF0, 8'h01, "dis_pending_kept");
      m = cyc;
      push(m + 1, 1'b1, 8'h01, "dis_pre_clr");
      push(m + 2, 1'b1, 8'h00, "dis_drop");
      wr(8'hF0, 8'h01);
      idle(2);

      // Set wins over same-cycle clear.
      addr = 8'hF0; data_in = 8'h04; write_en = 1'b1; src_in = 8'h04;
      tick();
      write_en = 1'b0; addr = 8'h00; src_in = 8'h00;
      rd(8'hF0, 8'h04, "set_wins");
      wr(8'hF0, 8'h04);
      rd(8'hF0, 8'h00, "set_cleared");

      // Outside the window.
      wr(8'hF5, 8'hAA);
      rd(8'hF1, 8'h01, "oob_mask");
      rd(8'hF2, 8'h0C, "oob_route_lo");
      rd(8'hF3, 8'h00, "oob_route_hi");
      rd(8'hF4, 8'hFF, "oob_edge");
      rd(8'hF5, 8'h00, "oob_read");
      rd(8'hEF, 8'h00, "below_base");

      // Reset beats a same-cycle write.
      reset = 1'b1;
      addr = 8'hF1; data_in = 8'hFF; write_en = 1'b1;
      tick();
      reset = 1'b0; write_en = 1'b0; addr = 8'h00;
      rd(8'hF1, 8'h00, "rst_prio_mask");
      rd(8'hF2, 8'h00, "rst_prio_route");

      idle(3);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
